// File: rtl/serializador_matriz.sv
// Serializer for a packed DIM x DIM signed-byte matrix: captures on request and streams
// elements row-major with row/column tags, using a one-deep pending buffer for gapless reuse.
module serializador_matriz #(
   parameter int unsigned DIM    = 5,
   parameter int unsigned ELEM_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       capture,
   input  logic [DIM*DIM*ELEM_W-1:0]  matriz_in,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [ELEM_W-1:0]          out_data,
   output logic [$clog2(DIM)-1:0]     out_linha,
   output logic [$clog2(DIM)-1:0]     out_coluna,
   output logic                       out_last,
   output logic                       busy,
   output logic                       pend_full,
   output logic                       overrun,
   input  logic                       clear_overrun
);

   localparam int unsigned NElem = DIM * DIM;
   localparam int unsigned MatW  = NElem * ELEM_W;
   localparam int unsigned IW    = $clog2(NElem);
   localparam int unsigned LW    = $clog2(DIM);
   localparam logic [IW-1:0] LastIdx = IW'(NElem - 1);
   localparam logic [LW-1:0] ColMax  = LW'(DIM - 1);

   typedef enum logic {StIdle, StSend} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [LW-1:0]       lin_q, lin_d;
   logic [LW-1:0]       col_q, col_d;
   logic [MatW-1:0]     active_q, active_d;
   logic [MatW-1:0]     pending_q, pending_d;
   logic                pend_full_q, pend_full_d;
   logic                overrun_q, overrun_d;
   logic [ELEM_W-1:0]   data_q, data_d;
   logic                last_q, last_d;

   logic xfer, last_xfer, drop;

   assign xfer      = (state_q == StSend) && out_ready;
   assign last_xfer = xfer && (idx_q == LastIdx);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lin_d       = lin_q;
      col_d       = col_q;
      active_d    = active_q;
      pending_d   = pending_q;
      pend_full_d = pend_full_q;
      overrun_d   = overrun_q;
      drop        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (capture) begin
               active_d = matriz_in;
               idx_d    = '0;
               lin_d    = '0;
               col_d    = '0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (last_xfer) begin
               idx_d = '0;
               lin_d = '0;
               col_d = '0;
               if (pend_full_q) begin
                  active_d = pending_q;
                  if (capture) begin
                     pending_d = matriz_in;
                  end else begin
                     pend_full_d = 1'b0;
                  end
               end else if (capture) begin
                  active_d = matriz_in;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + 1'b1;
                  if (col_q == ColMax) begin
                     col_d = '0;
                     lin_d = lin_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
               if (capture) begin
                  if (!pend_full_q) begin
                     pending_d   = matriz_in;
                     pend_full_d = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A dropped capture outranks a simultaneous clear.
      if (clear_overrun) overrun_d = 1'b0;
      if (drop)          overrun_d = 1'b1;
   end

   // Output element is selected from next-state so out_data lines up with the registered tags.
   always_comb begin
      data_d = '0;
      for (int i = 0; i < int'(NElem); i++) begin
         if (idx_d == IW'(i)) data_d = active_d[ELEM_W*i +: ELEM_W];
      end
      last_d = (state_d == StSend) && (idx_d == LastIdx);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         lin_q       <= '0;
         col_q       <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lin_q       <= lin_d;
         col_q       <= col_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pend_full_q <= pend_full_d;
         overrun_q   <= overrun_d;
         data_q      <= data_d;
         last_q      <= last_d;
      end
   end

   assign out_valid  = (state_q == StSend);
   assign busy       = (state_q == StSend);
   assign out_data   = data_q;
   assign out_linha  = lin_q;
   assign out_coluna = col_q;
   assign out_last   = last_q;
   assign pend_full  = pend_full_q;
   assign overrun    = overrun_q;

   a_hold: assert property (@(posedge clock) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_linha)
                                     && $stable(out_coluna) && $stable(out_last)));

   a_last: assert property (@(posedge clock) disable iff (reset)
      out_last |-> (out_valid && out_linha == ColMax && out_coluna == ColMax));

endmodule

// File: doc/serializador_matriz.md
# serializador_matriz

Reader/serializer for the packed 5x5 signed-byte matrix bus produced by the matrix multiplier. It captures a 200-bit packed matrix on request and streams it out one element per handshake in row-major order, with row/column tags and a last-element flag. A one-deep pending buffer allows back-to-back captures without bubbles. It sits between the multiplier's `resultado` bus and any byte-wide consumer, such as a UART TX or a display driver.

## Interface
- `DIM`, 5, matrix dimension (rows = columns)
- `ELEM_W`, 8, element width in bits, two's complement
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `capture`  in  1  single-cycle request to latch `matriz_in`
- `matriz_in`  in  DIM*DIM*ELEM_W (200)  packed matrix; element (l,c) at bits [ELEM_W*(c+DIM*l) +: ELEM_W]
- `out_ready`  in  1  consumer accepts the current element
- `out_valid`  out  1  `out_data` holds a valid element
- `out_data`  out  ELEM_W  current element, signed
- `out_linha`  out  3  row index of the current element
- `out_coluna`  out  3  column index of the current element
- `out_last`  out  1  current element is (DIM-1, DIM-1)
- `busy`  out  1  active matrix being streamed
- `pend_full`  out  1  pending buffer occupied
- `overrun`  out  1  sticky: a capture was dropped
- `clear_overrun`  in  1  synchronous clear of `overrun`

## Operation
- Storage: active register (200 bits), pending register (200 bits), element index 0..DIM*DIM-1.
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - SEND: `busy`=1, `out_valid`=1.
- Element order is row-major from index 0: (0,0), (0,1) … (0,4), (1,0) … (4,4).
- `out_data` = active[ELEM_W*idx +: ELEM_W], with `out_linha` = idx/DIM and `out_coluna` = idx%DIM.
- Transfer occurs when `out_valid` and `out_ready` are both high.
  - On a non-last transfer, idx advances by 1.
  - On the last transfer (idx = DIM*DIM-1), idx returns to 0.
- IDLE with `capture`: active <= `matriz_in`, idx <= 0, go to SEND.
- SEND with `capture` and no last transfer in the same cycle:
  - Pending empty: pending <= `matriz_in`, `pend_full` <= 1.
  - Pending full: the capture is dropped and `overrun` <= 1. Active and pending are unchanged.
- Last transfer in SEND:
  - Pending full: active <= pending, idx <= 0, stay in SEND with no bubble. If `capture` is also high, pending <= `matriz_in` and `pend_full` stays 1; otherwise `pend_full` <= 0.
  - Pending empty, `capture` high: active <= `matriz_in`, idx <= 0, stay in SEND.
  - Pending empty, no `capture`: go to IDLE.
- `clear_overrun` clears `overrun`. If `clear_overrun` and a dropping capture occur in the same cycle, set wins.
- No arithmetic on data; element bits are passed through unchanged, including sign.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_linha`=0, `out_coluna`=0, `out_last`=0, `busy`=0, `pend_full`=0, `overrun`=0. idx=0, state=IDLE, active and pending = 0.
- All outputs are registered.
- Latency: `capture` at edge N in IDLE gives `out_valid`=1 with element (0,0) after edge N.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_linha`, `out_coluna` and `out_last` are held stable.
- `out_valid` never drops until the last transfer.
- Throughput: one element per cycle with `out_ready` held high.
  - 25 cycles per matrix.
  - Back-to-back matrices run with no idle cycle.
- `matriz_in` is sampled only on the `capture` edge; later changes to it have no effect.
- Asserting `reset` mid-stream immediately returns all state to reset values, with no partial transfer completing.

## Test plan
- Reset, then `capture` of a matrix with element k = k+1, `out_ready`=1:
  - Required: 25 transfers with data 1..25 in row-major order.
  - `out_last` high only on data 25 (linha=4, coluna=4).
  - `busy` low on the cycle after the last transfer.
- Negative values (0x80, 0xFF at (2,3)) with random `out_ready` stalls:
  - Required: exact bytes delivered in order.
  - Outputs stable during stalls.
  - No element duplicated or skipped.
- Capture B during streaming of A; `out_ready`=1:
  - Required: A(4,4) is followed on the next cycle by B(0,0).
  - `pend_full` is 1 from capture until the last transfer of A.
- Captures B and C during A (pending full):
  - Required: C is dropped and `overrun`=1; B is streamed next.
  - `clear_overrun` pulse returns `overrun` to 0.
- `capture` coincident with the last transfer of A, pending empty:
  - Required: the captured matrix starts at (0,0) on the next cycle with no bubble.
  - `pend_full` stays 0.
- `reset` asserted at element 12:
  - Required: `out_valid` and `busy` are 0 immediately.
  - A new `capture` then restarts at (0,0).
